// File: rtl/alu_op_queue.sv
// Operand/opcode queue feeding the 4-bit ALU with 8-bit accumulator.
// Captures pushes into a FIFO and replays them as setup + Load pulses.
module alu_op_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          Clk,
    input  logic          Reset_b,
    input  logic          Wr_req,
    input  logic [3:0]    Wr_data,
    input  logic [2:0]    Wr_sel,
    input  logic          Run,
    input  logic          Flush,
    output logic [3:0]    Data,
    output logic [2:0]    Select,
    output logic          Load,
    output logic          Busy,
    output logic          Full,
    output logic          Empty,
    output logic [AW:0]   Count,
    output logic          Overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        LOAD    = 2'd2
    } state_t;

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_t        state;
    state_t        state_n;
    logic [6:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] head_addr;
    logic [6:0]    head;
    logic          wr_q;
    logic          push;
    logic          accept;
    logic          pop;
    logic          ld_op;

    assign push    = Wr_req & ~wr_q;
    assign accept  = push & ~Full;
    assign pop     = (state == LOAD);
    assign Full    = (Count == CNT_FULL);
    assign Empty   = (Count == '0);
    assign Busy    = (state != IDLE);
    assign Load    = (state == LOAD);

    // In LOAD the entry at rptr is leaving, so the next head is one beyond it
    assign head_addr = (state == LOAD) ? rptr + PTR_ONE : rptr;
    assign head      = mem[head_addr];

    // Previous Wr_req level for rising-edge push detection
    always_ff @(posedge Clk or negedge Reset_b) begin
        if (!Reset_b) wr_q <= 1'b0;
        else          wr_q <= Wr_req;
    end

    // Storage array; a Flush suppresses the write
    always_ff @(posedge Clk) begin
        if (accept && !Flush) mem[wptr] <= {Wr_sel, Wr_data};
    end

    // Pointers, occupancy and sticky overflow flag
    always_ff @(posedge Clk or negedge Reset_b) begin
        if (!Reset_b) begin
            wptr     <= '0;
            rptr     <= '0;
            Count    <= '0;
            Overflow <= 1'b0;
        end else if (Flush) begin
            wptr     <= '0;
            rptr     <= '0;
            Count    <= '0;
            Overflow <= 1'b0;
        end else begin
            if (accept)      wptr     <= wptr + PTR_ONE;
            if (pop)         rptr     <= rptr + PTR_ONE;
            if (push && Full) Overflow <= 1'b1;
            unique case ({accept, pop})
                2'b10:   Count <= Count + CNT_ONE;
                2'b01:   Count <= Count - CNT_ONE;
                default: Count <= Count;
            endcase
        end
    end

    // Issue sequencer: next state and when to latch a new head entry
    always_comb begin
        state_n = state;
        ld_op   = 1'b0;
        unique case (state)
            IDLE: begin
                if (Run && !Empty) begin
                    state_n = PRESENT;
                    ld_op   = 1'b1;
                end
            end
            PRESENT: state_n = LOAD;
            LOAD: begin
                if (Run && (Count > CNT_ONE)) begin
                    state_n = PRESENT;
                    ld_op   = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (Flush) begin
            state_n = IDLE;
            ld_op   = 1'b0;
        end
    end

    // State register and the operand/select registers driven to the ALU
    always_ff @(posedge Clk or negedge Reset_b) begin
        if (!Reset_b) begin
            state  <= IDLE;
            Data   <= '0;
            Select <= '0;
        end else begin
            state <= state_n;
            if (ld_op) {Select, Data} <= head;
        end
    end

endmodule
